// File: rtl/fma16_issue.sv
// Issue/response front end for the combinational fma16 datapath: registers the
// operands and decoded controls, waits EXEC_CYCLES, then returns result and flags.
module fma16_issue #(
  parameter int TAGW        = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [15:0]     req_x,
  input  logic [15:0]     req_y,
  input  logic [15:0]     req_z,
  input  logic [1:0]      req_rm,
  input  logic [TAGW-1:0] req_tag,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [15:0]     resp_result,
  output logic [3:0]      resp_flags,
  output logic [TAGW-1:0] resp_tag,
  output logic            resp_err,
  output logic [3:0]      fflags,
  input  logic            fflags_clr,
  output logic [15:0]     fma_x,
  output logic [15:0]     fma_y,
  output logic [15:0]     fma_z,
  output logic            fma_mul,
  output logic            fma_add,
  output logic            fma_negr,
  output logic            fma_negz,
  output logic [1:0]      fma_roundmode,
  input  logic [15:0]     fma_result,
  input  logic [3:0]      fma_flags
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [3:0]  CNT_INIT = 4'(EXEC_CYCLES - 1);
  localparam logic [15:0] FP_ONE   = 16'h3C00;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [15:0]     x_q, x_d, y_q, y_d, z_q, z_d;
  logic [3:0]      ctl_q, ctl_d;   // {mul, add, negr, negz}
  logic [1:0]      rm_q, rm_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [15:0]     result_q, result_d;
  logic [3:0]      flags_q, flags_d;
  logic            err_q, err_d;
  logic [3:0]      fflags_q, fflags_d;

  logic [3:0]      dec_ctl;
  logic            dec_rsvd;
  logic            capture;

  always_comb begin
    dec_rsvd = 1'b0;
    case (req_op)
      3'b000:  dec_ctl = 4'b0100;
      3'b001:  dec_ctl = 4'b0101;
      3'b010:  dec_ctl = 4'b1000;
      3'b011:  dec_ctl = 4'b1100;
      3'b100:  dec_ctl = 4'b1101;
      3'b101:  dec_ctl = 4'b1111;
      3'b110:  dec_ctl = 4'b1110;
      default: begin
        dec_ctl  = 4'b0000;
        dec_rsvd = 1'b1;
      end
    endcase
  end

  assign capture = (state_q == S_EXEC) && (cnt_q == 4'd0);

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    ctl_d    = ctl_q;
    rm_d     = rm_q;
    tag_d    = tag_q;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          x_d   = req_x;
          y_d   = dec_ctl[3] ? req_y : FP_ONE;  // add-only ops multiply by 1.0
          z_d   = req_z;
          ctl_d = dec_ctl;
          rm_d  = req_rm;
          tag_d = req_tag;
          cnt_d = CNT_INIT;
          if (dec_rsvd) begin
            result_d = 16'h0000;
            flags_d  = 4'b0000;
            err_d    = 1'b1;
            state_d  = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          result_d = fma_result;
          flags_d  = fma_flags;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Clear first, then accumulate the flags of an op finishing this cycle.
    fflags_d = (fflags_clr ? 4'b0000 : fflags_q) | (capture ? fma_flags : 4'b0000);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      x_q      <= 16'h0000;
      y_q      <= 16'h0000;
      z_q      <= 16'h0000;
      ctl_q    <= 4'b0000;
      rm_q     <= 2'b00;
      tag_q    <= '0;
      result_q <= 16'h0000;
      flags_q  <= 4'b0000;
      err_q    <= 1'b0;
      fflags_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      ctl_q    <= ctl_d;
      rm_q     <= rm_d;
      tag_q    <= tag_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
      fflags_q <= fflags_d;
    end
  end

  // Handshake outputs come from state only; reset gating holds ready low in reset.
  assign req_ready     = (state_q == S_IDLE) && !reset;
  assign resp_valid    = (state_q == S_RESP);
  assign resp_result   = result_q;
  assign resp_flags    = flags_q;
  assign resp_tag      = tag_q;
  assign resp_err      = err_q;
  assign fflags        = fflags_q;
  assign fma_x         = x_q;
  assign fma_y         = y_q;
  assign fma_z         = z_q;
  assign fma_mul       = ctl_q[3];
  assign fma_add       = ctl_q[2];
  assign fma_negr      = ctl_q[1];
  assign fma_negz      = ctl_q[0];
  assign fma_roundmode = rm_q;

endmodule

// File: tb/tb_fma16_issue.sv
// Directed bench for fma16_issue; a stand-in fma16 returns the vector's result
// only while the DUT drives the expected operands and controls.
module tb_fma16_issue;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] x, y, z;
    logic [1:0]  rm;
    logic [3:0]  tag;
    logic [15:0] fy;    // operand expected on fma_y
    logic [3:0]  ctl;   // expected {mul, add, negr, negz}
    logic [15:0] res;
    logic [3:0]  flg;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  req_op = '0;
  logic [15:0] req_x = '0, req_y = '0, req_z = '0;
  logic [1:0]  req_rm = '0;
  logic [3:0]  req_tag = '0;
  logic        resp_valid, resp_ready = 1'b0;
  logic [15:0] resp_result;
  logic [3:0]  resp_flags, resp_tag, fflags;
  logic        resp_err, fflags_clr = 1'b0;
  logic [15:0] fma_x, fma_y, fma_z, fma_result;
  logic        fma_mul, fma_add, fma_negr, fma_negz;
  logic [1:0]  fma_roundmode;
  logic [3:0]  fma_flags;

  logic [15:0] m_x = '0, m_y = '0, m_z = '0, m_res = '0;
  logic [3:0]  m_ctl = '0, m_flg = '0;
  logic [1:0]  m_rm = '0;
  logic        match;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign match = (fma_x == m_x) && (fma_y == m_y) && (fma_z == m_z) &&
                 ({fma_mul, fma_add, fma_negr, fma_negz} == m_ctl) &&
                 (fma_roundmode == m_rm);
  assign fma_result = match ? m_res : 16'hBAD0;
  assign fma_flags  = match ? m_flg : 4'hF;

  fma16_issue #(.TAGW(4), .EXEC_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_rm(req_rm), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_flags(resp_flags), .resp_tag(resp_tag), .resp_err(resp_err),
    .fflags(fflags), .fflags_clr(fflags_clr),
    .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
    .fma_mul(fma_mul), .fma_add(fma_add), .fma_negr(fma_negr), .fma_negz(fma_negz),
    .fma_roundmode(fma_roundmode), .fma_result(fma_result), .fma_flags(fma_flags)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [2:0] op, logic [15:0] x, logic [15:0] y, logic [15:0] z,
                              logic [1:0] rm, logic [3:0] tag, logic [15:0] fy,
                              logic [3:0] ctl, logic [15:0] res, logic [3:0] flg);
    vec_t v;
    v.op = op; v.x = x; v.y = y; v.z = z; v.rm = rm; v.tag = tag;
    v.fy = fy; v.ctl = ctl; v.res = res; v.flg = flg;
    return v;
  endfunction

  task automatic start_req(input vec_t v);
    req_op = v.op; req_x = v.x; req_y = v.y; req_z = v.z; req_rm = v.rm; req_tag = v.tag;
    m_x = v.x; m_y = v.fy; m_z = v.z; m_ctl = v.ctl; m_rm = v.rm;
    m_res = v.res; m_flg = v.flg;
    req_valid = 1'b1;
  endtask

  // Call away from the rising edge; returns just after the accepting edge.
  task automatic wait_accept();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int lat);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!resp_valid && k < 20);
    check("resp_latency", k, lat);
  endtask

  task automatic check_resp(input vec_t v, input logic [15:0] res, input logic [3:0] flg,
                            input logic err);
    check("resp_result", resp_result, res);
    check("resp_flags", resp_flags, flg);
    check("resp_tag", resp_tag, v.tag);
    check("resp_err", resp_err, err);
  endtask

  task automatic ack_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    start_req(v);
    wait_accept();
    check("fma_ctl", {fma_mul, fma_add, fma_negr, fma_negz}, v.ctl);
    check("fma_y", fma_y, v.fy);
    wait_resp(2);
    check_resp(v, v.res, v.flg, 1'b0);
    ack_resp();
  endtask

  vec_t v_mul, v_add, v_fmadd, v_inf, v_bp1, v_bp2, v_nx, v_rsv, v_rst;
  vec_t v_tab[3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    v_mul   = mk(3'b010, 16'h3C00, 16'h4000, 16'h0000, 2'b01, 4'h1, 16'h4000, 4'b1000, 16'h4000, 4'b0000);
    v_add   = mk(3'b000, 16'h3C00, 16'h1234, 16'h3C00, 2'b01, 4'h2, 16'h3C00, 4'b0100, 16'h4000, 4'b0000);
    v_fmadd = mk(3'b011, 16'h7BFF, 16'h4000, 16'h0000, 2'b01, 4'h3, 16'h4000, 4'b1100, 16'h7C00, 4'b0101);
    v_inf   = mk(3'b010, 16'h7C00, 16'h0000, 16'h0000, 2'b01, 4'h4, 16'h0000, 4'b1000, 16'h7E00, 4'b1000);
    v_bp1   = mk(3'b010, 16'h3C00, 16'h4000, 16'h0000, 2'b01, 4'hA, 16'h4000, 4'b1000, 16'h4000, 4'b0000);
    v_bp2   = mk(3'b001, 16'h4000, 16'h7777, 16'h3C00, 2'b00, 4'h5, 16'h3C00, 4'b0101, 16'h3C00, 4'b0000);
    v_tab[0] = mk(3'b100, 16'h3C00, 16'h4000, 16'h3C00, 2'b10, 4'h6, 16'h4000, 4'b1101, 16'h3C00, 4'b0000);
    v_tab[1] = mk(3'b101, 16'h3C00, 16'h3C00, 16'h3C00, 2'b11, 4'h7, 16'h3C00, 4'b1111, 16'hC000, 4'b0000);
    v_tab[2] = mk(3'b110, 16'h3C00, 16'h3C00, 16'h3C00, 2'b01, 4'h8, 16'h3C00, 4'b1110, 16'h0000, 4'b0000);
    v_nx    = mk(3'b000, 16'h3C00, 16'h0000, 16'h0001, 2'b01, 4'h9, 16'h3C00, 4'b0100, 16'h3C00, 4'b0001);
    // Stand-in returns 5555/F here; a reserved op must never capture it.
    v_rsv   = mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 2'b01, 4'hB, 16'h3C00, 4'b0000, 16'h5555, 4'hF);
    v_rst   = mk(3'b010, 16'h3C00, 16'h4000, 16'h0000, 2'b01, 4'hC, 16'h4000, 4'b1000, 16'h4000, 4'b0000);

    // Reset state
    @(negedge clk);
    check("ready_in_reset", req_ready, 1'b0);
    check("valid_in_reset", resp_valid, 1'b0);
    check("fflags_rst", fflags, 4'b0000);
    check("fma_ops_rst", {fma_x, fma_y, fma_z}, 48'h0);
    check("fma_ctl_rst", {fma_mul, fma_add, fma_negr, fma_negz, fma_roundmode}, 6'b0);
    check("resp_rst", {resp_result, resp_flags, resp_tag, resp_err}, 25'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1'b1);

    run_op(v_mul);
    run_op(v_add);
    run_op(v_fmadd);
    run_op(v_inf);
    check("fflags_accum", fflags, 4'b1101);
    for (int i = 0; i < 3; i++) run_op(v_tab[i]);
    check("fflags_kept", fflags, 4'b1101);

    // Backpressure with a second request pending
    start_req(v_bp1);
    wait_accept();
    wait_resp(2);
    check_resp(v_bp1, 16'h4000, 4'b0000, 1'b0);
    start_req(v_bp2);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", resp_valid, 1'b1);
      check("bp_ready", req_ready, 1'b0);
      check("bp_result", resp_result, 16'h4000);
      check("bp_tag", resp_tag, 4'hA);
      @(negedge clk);
    end
    ack_resp();
    @(negedge clk);
    check("bp_ready_after_ack", req_ready, 1'b1);
    check("bp_valid_after_ack", resp_valid, 1'b0);
    wait_accept();
    check("bp_ready_after_accept", req_ready, 1'b0);
    wait_resp(2);
    check_resp(v_bp2, 16'h3C00, 4'b0000, 1'b0);
    ack_resp();

    // fflags clear alone, then clear coinciding with a capture
    fflags_clr = 1'b1;
    @(posedge clk);
    #1 fflags_clr = 1'b0;
    check("fflags_clr_alone", fflags, 4'b0000);
    run_op(v_inf);
    check("fflags_before_clr", fflags, 4'b1000);
    start_req(v_nx);
    wait_accept();
    fflags_clr = 1'b1;
    @(posedge clk);
    #1 fflags_clr = 1'b0;
    check("fflags_clr_capture", fflags, 4'b0001);
    wait_resp(1);
    check_resp(v_nx, 16'h3C00, 4'b0001, 1'b0);
    ack_resp();

    // Reserved opcode
    start_req(v_rsv);
    wait_accept();
    wait_resp(1);
    check_resp(v_rsv, 16'h0000, 4'b0000, 1'b1);
    ack_resp();
    check("fflags_rsvd", fflags, 4'b0001);

    // Reset during EXEC
    start_req(v_rst);
    wait_accept();
    reset = 1'b1;
    @(negedge clk);
    check("ready_mid_reset", req_ready, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_ready", req_ready, 1'b1);
    check("abort_fflags", fflags, 4'b0000);
    check("abort_fma_ops", {fma_x, fma_y, fma_z}, 48'h0);
    check("abort_fma_ctl", {fma_mul, fma_add, fma_negr, fma_negz, fma_roundmode}, 6'b0);
    check("abort_resp", {resp_result, resp_flags, resp_tag, resp_err}, 25'h0);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_resp", resp_valid, 1'b0);
      @(negedge clk);
    end

    run_op(v_mul);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fma16_issue.md
# fma16_issue

Sequential issue/response front end for the combinational `fma16` datapath. It accepts half-precision operation requests over a valid/ready handshake and decodes a 3-bit opcode into the `mul/add/negr/negz` controls. It holds operands stable in registers while `fma16` evaluates, then returns the result and per-operation flags over a second valid/ready handshake. It also keeps a sticky accumulated-exception register (fflags) for the CSR side.

## Interface
- `TAGW`, default 4: request/response tag width.
- `EXEC_CYCLES`, default 1: cycles operands are held on the `fma16` inputs before capture (multicycle-path allowance); legal range 1–15.

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_op` in 3: opcode.
- `req_x`, `req_y`, `req_z` in 16 each: operands.
- `req_rm` in 2: rounding mode, passed through. Encoding: 00 RZ, 01 RNE, 10 RDN, 11 RUP.
- `req_tag` in TAGW: returned unchanged with the response.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_result` out 16: rounded result.
- `resp_flags` out 4: `{nv,of,uf,nx}` for this operation.
- `resp_tag` out TAGW: tag of this operation.
- `resp_err` out 1: reserved opcode.
- `fflags` out 4: sticky OR of all completed `resp_flags`.
- `fflags_clr` in 1: clear `fflags`.
- `fma_x`, `fma_y`, `fma_z` out 16 each: drive `fma16` operands.
- `fma_mul`, `fma_add`, `fma_negr`, `fma_negz` out 1 each: drive `fma16` controls.
- `fma_roundmode` out 2: drive `fma16` rounding mode.
- `fma_result` in 16: `fma16` result.
- `fma_flags` in 4: `fma16` flags.

## Operation
- Opcode decode (mul, add, negr, negz):
  - 000 fadd: 0,1,0,0
  - 001 fsub: 0,1,0,1
  - 010 fmul: 1,0,0,0
  - 011 fmadd: 1,1,0,0
  - 100 fmsub: 1,1,0,1
  - 101 fnmadd: 1,1,1,1
  - 110 fnmsub: 1,1,1,0
  - 111 reserved
- Operand and control registers:
  - Loaded on request handshake (`req_valid & req_ready`) and driven onto the `fma_*` ports until the next accept.
  - When mul=0, `fma_y` = 16'h3C00 (1.0) regardless of `req_y`.
- States:
  - IDLE: `req_ready`=1. On handshake, load registers, set the counter to EXEC_CYCLES-1, go to EXEC. A reserved op instead goes directly to RESP with result 16'h0000, flags 0000, `resp_err`=1.
  - EXEC: `req_ready`=0. The counter decrements each cycle. When the counter is 0, capture `fma_result`/`fma_flags` into the response registers, OR `fma_flags` into `fflags`, and go to RESP.
  - RESP: `resp_valid`=1, and all `resp_*` outputs are held stable until `resp_ready`=1. On that handshake go to IDLE. `req_ready` is 0 in RESP, so there is no overlap.
- `fflags` update:
  - Reserved ops do not modify `fflags`.
  - `fflags_clr` alone sets `fflags` to 0.
  - `fflags_clr` in the same cycle as an EXEC capture sets `fflags` to the captured `fma_flags` (clear takes effect first, then the OR).
- Reset, including mid-operation: state goes to IDLE and the in-flight operation is discarded with no response. Reset values:
  - `req_ready`=0 during reset, 1 the cycle after.
  - `resp_valid`=0, `resp_err`=0, `fflags`=0.
  - `resp_result`, `resp_flags`, `resp_tag` = 0.
  - `fma_*` operands = 0, all controls = 0, `fma_roundmode` = 00.

## Timing
- Request accepted at edge N, so EXEC runs cycles N+1 … N+EXEC_CYCLES.
- Capture happens at edge N+EXEC_CYCLES. `resp_valid` is high from cycle N+EXEC_CYCLES+1.
- Latency (accept to `resp_valid`): EXEC_CYCLES+1. Reserved op: 1.
- Best-case throughput: one op per EXEC_CYCLES+2 cycles (response accepted immediately).
- `req_ready` and `resp_valid` depend only on state, with no combinational path from `req_valid` or `resp_ready`.
- Requests with `req_ready`=0 are ignored. The source must hold its request until the handshake.

## Test plan
- fmul, x=3C00, y=4000, rm=01 -> `resp_result`=4000, `resp_flags`=0000, `resp_valid` exactly 2 cycles after accept (EXEC_CYCLES=1).
- fadd, x=3C00, y=1234, z=3C00 -> `fma_y` observed as 3C00, `fma_mul`=0, `fma_add`=1; result 4000, flags 0000.
- fmadd, x=7BFF, y=4000, z=0000, rm=01 -> result 7C00, flags 0101. Then fmul, x=7C00, y=0000 -> result 7E00, flags 1000; `fflags`=1101 after both.
- Backpressure: hold `resp_ready`=0 for 5 cycles with a second request pending -> `resp_*` stable, `req_ready`=0, second request accepted only in the cycle after the response handshake. Tag 4'hA on the first request returns as `resp_tag`=A.
- `fflags_clr` asserted in the capture cycle of an op returning flags 0001, with `fflags`=1000 beforehand -> `fflags`=0001. Reserved op 111 -> `resp_err`=1, result 0000, `fflags` unchanged.
- Assert `reset` during EXEC -> next cycle in IDLE with `resp_valid`=0, `fflags`=0, all `fma_*` outputs 0, and no response emitted for the aborted op.
